// File: rtl/score_tally_if.sv
// Judgement inputs and HUD-facing tally outputs shared between the droppers,
// the keyboard decoder and score_tally.
interface score_tally_if #(
    parameter int unsigned NUM_LANES = 4
);
    logic [7:0]             keycode;
    logic [NUM_LANES-1:0]   score_in;
    logic [10*NUM_LANES-1:0] dropY_in;

    logic [13:0]            score;
    logic [9:0]             combo;
    logic [9:0]             max_combo;
    logic [7:0]             hit_count;
    logic [7:0]             miss_count;
    logic                   hit_pulse;
    logic                   miss_pulse;
    logic                   done;

    modport master (
        output keycode, score_in, dropY_in,
        input  score, combo, max_combo, hit_count, miss_count,
               hit_pulse, miss_pulse, done
    );

    modport slave (
        input  keycode, score_in, dropY_in,
        output score, combo, max_combo, hit_count, miss_count,
               hit_pulse, miss_pulse, done
    );
endinterface

// File: rtl/score_tally.sv
// Per-round hit/miss tally: edge-detects one judgement per lane, accumulates
// score and combo statistics, and flags the round done once every lane resolves.
module score_tally #(
    parameter int unsigned NUM_LANES  = 4,
    parameter int unsigned MISS_Y     = 360,
    parameter int unsigned HIT_POINTS = 100,
    parameter int unsigned SCORE_MAX  = 9999,
    parameter logic [7:0]  KEY_START  = 8'h2c,
    parameter logic [7:0]  KEY_ABORT  = 8'h01
) (
    input  logic        frame_clk,
    input  logic        Reset,
    score_tally_if.slave bus
);
    localparam int unsigned CW = $clog2(NUM_LANES + 1);

    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

    state_t               state, state_next;
    logic [NUM_LANES-1:0] hit_cond, miss_cond, prev_hit, prev_miss;
    logic [NUM_LANES-1:0] resolved, resolved_next, hit_ev, miss_ev;
    logic [CW-1:0]        h_cnt, m_cnt;
    logic                 in_play;

    logic [13:0] score_q, score_next, score_sat;
    logic [9:0]  combo_q, combo_next, combo_sat;
    logic [9:0]  max_q, max_next;
    logic [7:0]  hit_q, hit_next, hit_sat;
    logic [7:0]  miss_q, miss_next, miss_sat;
    logic        hit_pulse_q, hit_pulse_next, miss_pulse_q, miss_pulse_next, done_q;
    logic [16:0] score_sum;
    logic [10:0] combo_sum;
    logic [8:0]  hit_sum, miss_sum;

    // Lane judgement conditions, rising-edge events and their popcounts
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            hit_cond[i]  = bus.score_in[i];
            miss_cond[i] = !bus.score_in[i] && (bus.dropY_in[10*i +: 10] >= 10'(MISS_Y));
        end
        in_play = (state == PLAY) && (bus.keycode != KEY_ABORT);
        hit_ev  = in_play ? (hit_cond  & ~prev_hit  & ~resolved) : '0;
        miss_ev = in_play ? (miss_cond & ~prev_miss & ~resolved) : '0;
        h_cnt = '0;
        m_cnt = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            h_cnt = h_cnt + CW'(hit_ev[i]);
            m_cnt = m_cnt + CW'(miss_ev[i]);
        end
    end

    // Saturating arithmetic candidates
    always_comb begin
        score_sum = 17'(score_q) + 17'(h_cnt) * 17'(HIT_POINTS);
        score_sat = (score_sum > 17'(SCORE_MAX)) ? 14'(SCORE_MAX) : score_sum[13:0];
        combo_sum = 11'(combo_q) + 11'(h_cnt);
        combo_sat = (combo_sum > 11'd1023) ? 10'd1023 : combo_sum[9:0];
        hit_sum   = 9'(hit_q) + 9'(h_cnt);
        hit_sat   = (hit_sum > 9'd255) ? 8'd255 : hit_sum[7:0];
        miss_sum  = 9'(miss_q) + 9'(m_cnt);
        miss_sat  = (miss_sum > 9'd255) ? 8'd255 : miss_sum[7:0];
    end

    // Next-state and next-counter logic
    always_comb begin
        state_next      = state;
        resolved_next   = resolved;
        score_next      = score_q;
        combo_next      = combo_q;
        max_next        = max_q;
        hit_next        = hit_q;
        miss_next       = miss_q;
        hit_pulse_next  = 1'b0;
        miss_pulse_next = 1'b0;
        case (state)
            IDLE: begin
                if (bus.keycode == KEY_START) begin
                    state_next    = PLAY;
                    resolved_next = '0;
                    score_next    = '0;
                    combo_next    = '0;
                    max_next      = '0;
                    hit_next      = '0;
                    miss_next     = '0;
                end
            end
            PLAY: begin
                if (bus.keycode == KEY_ABORT) begin
                    state_next = IDLE;
                end else begin
                    score_next      = score_sat;
                    combo_next      = (m_cnt != '0) ? 10'd0 : combo_sat;
                    max_next        = (combo_next > max_q) ? combo_next : max_q;
                    hit_next        = hit_sat;
                    miss_next       = miss_sat;
                    hit_pulse_next  = (h_cnt != '0);
                    miss_pulse_next = (m_cnt != '0);
                    resolved_next   = resolved | hit_ev | miss_ev;
                    if (&resolved_next) state_next = DONE;
                end
            end
            DONE: begin
                if (bus.keycode == KEY_ABORT) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            state       <= IDLE;
            prev_hit    <= '0;
            prev_miss   <= '0;
            resolved    <= '0;
            score_q     <= '0;
            combo_q     <= '0;
            max_q       <= '0;
            hit_q       <= '0;
            miss_q      <= '0;
            hit_pulse_q <= 1'b0;
            miss_pulse_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_next;
            prev_hit    <= hit_cond;
            prev_miss   <= miss_cond;
            resolved    <= resolved_next;
            score_q     <= score_next;
            combo_q     <= combo_next;
            max_q       <= max_next;
            hit_q       <= hit_next;
            miss_q      <= miss_next;
            hit_pulse_q <= hit_pulse_next;
            miss_pulse_q <= miss_pulse_next;
            done_q      <= (state_next == DONE);
        end
    end

    assign bus.score      = score_q;
    assign bus.combo      = combo_q;
    assign bus.max_combo  = max_q;
    assign bus.hit_count  = hit_q;
    assign bus.miss_count = miss_q;
    assign bus.hit_pulse  = hit_pulse_q;
    assign bus.miss_pulse = miss_pulse_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_score_tally.sv
// Directed bench for score_tally: a 4-lane instance for round flow and a
// 128-lane instance for same-cycle combo break and score saturation.
module tb_score_tally;
    logic frame_clk;
    logic Reset;
    int   total;
    int   passed;

    score_tally_if #(.NUM_LANES(4))   bus4();
    score_tally_if #(.NUM_LANES(128)) busw();

    score_tally #(.NUM_LANES(4)) u_dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus4)
    );

    score_tally #(.NUM_LANES(128)) u_wide (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (busw)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    initial begin
        total  = 0;
        passed = 0;
        Reset  = 1'b1;
        bus4.keycode  = 8'h00;
        bus4.score_in = '0;
        bus4.dropY_in = '0;
        busw.keycode  = 8'h00;
        busw.score_in = '0;
        busw.dropY_in = '0;
        #1 Reset = 1'b0;
        #1;
        check("rst_score", 32'(bus4.score), 0);
        check("rst_done",  32'(bus4.done), 0);
        check("rst_hits",  32'(bus4.hit_count), 0);
        #1 Reset = 1'b1;

        // Round 1: four lanes hit on separate cycles
        bus4.keycode = 8'h2c;
        tick();
        bus4.keycode = 8'h00;
        check("r1_start_done", 32'(bus4.done), 0);
        for (int i = 0; i < 4; i++) begin
            bus4.score_in[i] = 1'b1;
            tick();
            check("r1_hit_pulse", 32'(bus4.hit_pulse), 1);
            check("r1_score_step", 32'(bus4.score), 32'((i + 1) * 100));
        end
        check("r1_score", 32'(bus4.score), 400);
        check("r1_combo", 32'(bus4.combo), 4);
        check("r1_max",   32'(bus4.max_combo), 4);
        check("r1_hits",  32'(bus4.hit_count), 4);
        check("r1_done",  32'(bus4.done), 1);
        tick();
        check("r1_pulse_clear", 32'(bus4.hit_pulse), 0);
        bus4.keycode = 8'h2c;
        tick();
        check("done_ignores_start", 32'(bus4.done), 1);
        check("done_frozen_score",  32'(bus4.score), 400);
        bus4.keycode = 8'h01;
        tick();
        check("abort_from_done", 32'(bus4.done), 0);
        check("idle_holds_score", 32'(bus4.score), 400);
        bus4.keycode  = 8'h00;
        bus4.score_in = '0;
        tick();

        // Round 2: hit, hit, miss on lane 2, hit
        bus4.keycode = 8'h2c;
        tick();
        bus4.keycode = 8'h00;
        check("r2_cleared", 32'(bus4.score), 0);
        bus4.score_in = 4'b0001;
        tick();
        bus4.score_in = 4'b0011;
        tick();
        check("r2_combo2", 32'(bus4.combo), 2);
        check("r2_no_miss_pulse", 32'(bus4.miss_pulse), 0);
        bus4.dropY_in[20 +: 10] = 10'd360;
        tick();
        check("r2_miss_pulse", 32'(bus4.miss_pulse), 1);
        check("r2_miss_combo", 32'(bus4.combo), 0);
        bus4.score_in = 4'b1011;
        tick();
        check("r2_score", 32'(bus4.score), 300);
        check("r2_combo", 32'(bus4.combo), 1);
        check("r2_max",   32'(bus4.max_combo), 2);
        check("r2_misses", 32'(bus4.miss_count), 1);
        check("r2_miss_pulse_once", 32'(bus4.miss_pulse), 0);
        check("r2_done", 32'(bus4.done), 1);
        bus4.keycode = 8'h01;
        tick();
        bus4.keycode  = 8'h00;
        bus4.score_in = '0;
        bus4.dropY_in = '0;
        tick();

        // Round 3: held score flag yields one hit; later low-Y is ignored
        bus4.keycode = 8'h2c;
        tick();
        bus4.keycode  = 8'h00;
        bus4.score_in = 4'b0001;
        tick();
        check("r3_first_hit", 32'(bus4.hit_pulse), 1);
        repeat (9) tick();
        bus4.dropY_in[0 +: 10] = 10'd370;
        tick();
        check("r3_hits_once", 32'(bus4.hit_count), 1);
        check("r3_no_miss",   32'(bus4.miss_count), 0);
        bus4.score_in = 4'b0000;
        tick();
        check("r3_resolved_no_miss", 32'(bus4.miss_count), 0);
        check("r3_resolved_pulse",   32'(bus4.miss_pulse), 0);
        bus4.score_in = 4'b0110;
        tick();
        check("r3_score300", 32'(bus4.score), 300);
        check("r3_combo3",   32'(bus4.combo), 3);

        // Asynchronous reset mid-round, no clock edge
        #2 Reset = 1'b0;
        #1;
        check("async_rst_score", 32'(bus4.score), 0);
        check("async_rst_combo", 32'(bus4.combo), 0);
        check("async_rst_max",   32'(bus4.max_combo), 0);
        check("async_rst_hits",  32'(bus4.hit_count), 0);
        Reset = 1'b1;
        bus4.score_in = 4'b1110;
        tick();
        check("post_rst_idle", 32'(bus4.hit_count), 0);
        check("post_rst_pulse", 32'(bus4.hit_pulse), 0);

        // Round 4: abort in the same cycle as a hit
        bus4.score_in = '0;
        bus4.dropY_in = '0;
        tick();
        bus4.keycode = 8'h2c;
        tick();
        bus4.keycode  = 8'h00;
        bus4.score_in = 4'b0001;
        tick();
        check("r4_hit", 32'(bus4.hit_count), 1);
        bus4.keycode  = 8'h01;
        bus4.score_in = 4'b0011;
        tick();
        check("abort_drops_hit",   32'(bus4.hit_count), 1);
        check("abort_drops_pulse", 32'(bus4.hit_pulse), 0);
        check("abort_score",       32'(bus4.score), 100);
        bus4.keycode  = 8'h00;
        bus4.score_in = 4'b0111;
        tick();
        check("abort_is_idle", 32'(bus4.hit_count), 1);

        // Wide round: combo of 3 broken by a same-cycle hit and miss
        busw.keycode = 8'h2c;
        tick();
        busw.keycode = 8'h00;
        busw.score_in[12:10] = 3'b111;
        tick();
        check("w_combo3", 32'(busw.combo), 3);
        busw.score_in[0] = 1'b1;
        busw.dropY_in[10 +: 10] = 10'd360;
        tick();
        check("w_mix_score", 32'(busw.score), 400);
        check("w_mix_combo", 32'(busw.combo), 0);
        check("w_mix_max",   32'(busw.max_combo), 3);
        check("w_mix_hitp",  32'(busw.hit_pulse), 1);
        check("w_mix_missp", 32'(busw.miss_pulse), 1);
        busw.keycode = 8'h01;
        tick();
        busw.keycode  = 8'h00;
        busw.score_in = '0;
        busw.dropY_in = '0;
        tick();

        // Wide round: 99 hits then more, score saturates
        busw.keycode = 8'h2c;
        tick();
        busw.keycode = 8'h00;
        for (int i = 0; i < 99; i++) busw.score_in[i] = 1'b1;
        tick();
        check("w_score9900", 32'(busw.score), 9900);
        check("w_hits99",    32'(busw.hit_count), 99);
        busw.score_in[99] = 1'b1;
        tick();
        check("w_score_sat", 32'(busw.score), 9999);
        busw.score_in[100] = 1'b1;
        tick();
        check("w_score_hold", 32'(busw.score), 9999);
        check("w_hits101",    32'(busw.hit_count), 101);
        check("w_combo101",   32'(busw.combo), 101);
        check("w_not_done",   32'(busw.done), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/score_tally.md
Name: score_tally

Overview:
- Consumes the per-lane judgement outputs of the falling-note droppers: the lane score flag and the arrow Y position.
- Detects one hit or one miss event per lane per round.
- Keeps the running score, current combo, max combo and hit/miss totals.
- Flags round completion once every lane is resolved. Feeds the score/HUD display logic; runs on frame_clk alongside the droppers.

Parameters:
NUM_LANES, 4, number of dropper lanes monitored
MISS_Y, 360, dropY value at/after which an unscored arrow counts as missed (arrow top + 40 >= 400)
HIT_POINTS, 100, score added per hit
SCORE_MAX, 9999, score saturation value
KEY_START, 8'h2c, keycode that starts a round
KEY_ABORT, 8'h01, keycode that returns to idle

Ports:
frame_clk  in  1  frame clock, one tick per video frame
Reset  in  1  asynchronous, active-low reset
keycode  in  8  primary keycode from the keyboard interface
score_in  in  NUM_LANES  per-lane dropper score flag; level, high after a hit until the dropper halts
dropY_in  in  10*NUM_LANES  per-lane arrow Y; lane i occupies bits [10i+9:10i]
score  out  14  accumulated score, binary
combo  out  10  current consecutive-hit count
max_combo  out  10  highest combo this round
hit_count  out  8  hits this round
miss_count  out  8  misses this round
hit_pulse  out  1  one-cycle pulse on any hit event
miss_pulse  out  1  one-cycle pulse on any miss event
done  out  1  high in DONE state

Behaviour:
- Reset low, asynchronous:
  - state=IDLE.
  - All counters 0; pulses 0; done=0.
  - prev_hit, prev_miss and resolved masks cleared.
- Per lane, combinational:
  - hit_cond[i] = score_in[i].
  - miss_cond[i] = !score_in[i] && dropY_in[i] >= MISS_Y.
- Edge detection, every cycle in every state:
  - prev_hit <= hit_cond; prev_miss <= miss_cond.
  - hit_ev[i] = hit_cond[i] & !prev_hit[i] & !resolved[i].
  - miss_ev[i] likewise, using miss_cond/prev_miss.
  - Events are generated only in PLAY.
  - A lane's first event sets resolved[i]; later events on that lane are ignored until the next start.
- IDLE:
  - Outputs hold their last values.
  - keycode==KEY_START -> PLAY next cycle; score, combo, max_combo, hit_count, miss_count and resolved are cleared on that transition.
- PLAY:
  - H = popcount(hit_ev), M = popcount(miss_ev), both computed the same cycle.
  - score <= min(score + H*HIT_POINTS, SCORE_MAX). Use a 17-bit intermediate; never wraps.
  - If M>0: combo <= 0. Hits in the same cycle still score but do not extend the combo.
  - Else: combo <= combo + H, saturating at 1023.
  - max_combo <= max(max_combo, combo_next).
  - hit_count += H and miss_count += M, each saturating at 255.
  - hit_pulse = (H>0) and miss_pulse = (M>0), registered, high for exactly one cycle after the event cycle.
  - When resolved_next is all ones -> DONE. The final cycle's counters are updated in the same cycle as the transition.
  - keycode==KEY_ABORT -> IDLE; counters hold. Abort takes priority over events in the same cycle: the events are dropped.
- DONE:
  - done=1; counters frozen; pulses 0.
  - keycode==KEY_ABORT -> IDLE. KEY_START is ignored here.
- KEY_START seen while in PLAY: ignored.
- Reset mid-round: immediate clear to reset state regardless of frame_clk.

Test Plan:
- Reset low mid-PLAY with score=300 -> all outputs 0 and state IDLE, with no clock edge needed.
- IDLE, keycode=8'h2c for 1 cycle, then lanes 0..3 score_in rise on separate cycles -> score=400, combo=4, max_combo=4, hit_count=4, four hit_pulses, then done=1.
- PLAY, lane0 hit, lane1 hit, lane2 dropY=360 with score_in=0, lane3 hit -> score=300, combo=1, max_combo=2, miss_count=1, miss_pulse once.
- Same cycle: lane0 hit and lane1 miss with combo=3 beforehand -> score +100, combo=0, max_combo=3, hit_pulse and miss_pulse both high.
- score_in[0] held high 10 cycles, then dropY_in[0]=370 -> exactly one hit, no miss.
- score preloaded via 99 hits then more hits -> score saturates at 9999.
- KEY_ABORT in the same cycle as a hit -> state IDLE, hit_count unchanged.
